// File: rtl/fifo_burst_reader.sv
// -----------------------------------------------------------------------------
// fifo_burst_reader
//
// Read-side controller for a synchronous FIFO. It drains words in bursts
// through the FIFO read port and presents them downstream as a valid/ready
// stream. The final word of each burst or flush is tagged with out_last.
//
// Optional feature macro: FIFO_RD_TIMEOUT_EN
//   defined   : a partial flush (FLUSH state) runs when the FIFO has held
//               fewer than BURST words for TIMEOUT consecutive cycles.
//   undefined : only full bursts of BURST words are ever read.
//
// Ports
//   clk              in   rising-edge clock
//   reset_n          in   synchronous reset, active-low
//   fifo_empty       in   FIFO empty flag
//   fifo_data_count  in   FIFO occupancy
//   fifo_rdEn        out  FIFO read strobe, one word per high cycle
//   fifo_rdData      in   FIFO read data, valid one cycle after fifo_rdEn
//   out_valid        out  downstream word valid
//   out_ready        in   downstream accept
//   out_data         out  downstream word
//   out_last         out  final word of a burst or flush
//   busy             out  controller is not in IDLE
// -----------------------------------------------------------------------------
module fifo_burst_reader #(
  parameter int width   = 8,
  parameter int depth   = 8,
  parameter int BURST   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   fifo_empty,
  input  logic [$clog2(depth):0] fifo_data_count,
  output logic                   fifo_rdEn,
  input  logic [width-1:0]       fifo_rdData,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [width-1:0]       out_data,
  output logic                   out_last,
  output logic                   busy
);

  localparam int CW = $clog2(depth) + 1;
  localparam int TW = $clog2(BURST) + 1;

  localparam logic [CW-1:0] BURST_C = CW'(BURST);
  localparam logic [TW-1:0] BURST_T = TW'(BURST);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DRAIN = 2'd2
`ifdef FIFO_RD_TIMEOUT_EN
    , ST_FLUSH = 2'd3
`endif
  } state_e;

  state_e           state_q, state_d;
  logic [TW-1:0]    issued_q, issued_d;
  logic [TW-1:0]    target_q, target_d;
  logic             inflight_q, inflight_d;
  logic             inflight_last_q, inflight_last_d;

  // Two-entry output buffer, circular.
  logic [width-1:0] buf_data_q [2];
  logic [width-1:0] buf_data_d [2];
  logic             buf_last_q [2];
  logic             buf_last_d [2];
  logic [1:0]       occ_q, occ_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;

`ifdef FIFO_RD_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT) + 1;
  localparam logic [IW-1:0] TIMEOUT_M1 = IW'(TIMEOUT - 1);
  logic [IW-1:0]    idle_cnt_q, idle_cnt_d;
`endif

  logic in_read_state;
  logic credit_ok;
  logic rd_last;
  logic push;
  logic pop;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // through the block can leave one unassigned and infer a latch.
    state_d         = state_q;
    issued_d        = issued_q;
    target_d        = target_q;
    buf_data_d      = buf_data_q;
    buf_last_d      = buf_last_q;
    occ_d           = occ_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
`ifdef FIFO_RD_TIMEOUT_EN
    idle_cnt_d      = '0;
`endif

    out_valid = (occ_q != 2'd0);
    out_data  = buf_data_q[rd_ptr_q];
    out_last  = out_valid && buf_last_q[rd_ptr_q];
    busy      = (state_q != ST_IDLE);

`ifdef FIFO_RD_TIMEOUT_EN
    in_read_state = (state_q == ST_BURST) || (state_q == ST_FLUSH);
`else
    in_read_state = (state_q == ST_BURST);
`endif

    // occ + inflight < 2: one buffered word may coexist with one read in
    // flight, so every returning word always finds a free entry.
    credit_ok = (occ_q == 2'd0) || ((occ_q == 2'd1) && !inflight_q);
    fifo_rdEn = in_read_state && (issued_q < target_q) && !fifo_empty && credit_ok;

    // The target-th read carries the end-of-burst tag along with its data.
    rd_last         = (issued_q == target_q - TW'(1));
    inflight_d      = fifo_rdEn;
    inflight_last_d = fifo_rdEn && rd_last;

    push = inflight_q;
    pop  = out_valid && out_ready;

    if (push) begin
      buf_data_d[wr_ptr_q] = fifo_rdData;
      buf_last_d[wr_ptr_q] = inflight_last_q;
      wr_ptr_d             = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase

    case (state_q)
      ST_IDLE: begin
`ifdef FIFO_RD_TIMEOUT_EN
        if (fifo_empty) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q != TIMEOUT_M1) begin
          idle_cnt_d = idle_cnt_q + IW'(1);
        end else begin
          idle_cnt_d = idle_cnt_q;
        end
`endif
        if (fifo_data_count >= BURST_C) begin
          state_d  = ST_BURST;
          target_d = BURST_T;
          issued_d = '0;
`ifdef FIFO_RD_TIMEOUT_EN
        end else if (!fifo_empty && (idle_cnt_q == TIMEOUT_M1)) begin
          // The full-burst branch did not fire, so the count is already
          // below BURST and is the min(count, BURST) target.
          state_d  = ST_FLUSH;
          target_d = fifo_data_count[TW-1:0];
          issued_d = '0;
`endif
        end
      end
`ifdef FIFO_RD_TIMEOUT_EN
      ST_FLUSH,
`endif
      ST_BURST: begin
        if (fifo_rdEn) begin
          issued_d = issued_q + TW'(1);
        end
        if (issued_q == target_q) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!inflight_q && (occ_q == 2'd0)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q         <= ST_IDLE;
      issued_q        <= '0;
      target_q        <= '0;
      // Dropping inflight discards any read that returns after reset.
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      occ_q           <= 2'd0;
      wr_ptr_q        <= 1'b0;
      rd_ptr_q        <= 1'b0;
      // NOTE: the two buffer entries are reset because out_data is driven
      // straight from them and must read 0 out of reset; a larger storage
      // array would normally be left unreset.
      buf_data_q[0]   <= '0;
      buf_data_q[1]   <= '0;
      buf_last_q[0]   <= 1'b0;
      buf_last_q[1]   <= 1'b0;
`ifdef FIFO_RD_TIMEOUT_EN
      idle_cnt_q      <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments, so every flop samples the values
      // from before this edge regardless of statement order.
      state_q         <= state_d;
      issued_q        <= issued_d;
      target_q        <= target_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      occ_q           <= occ_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      buf_data_q      <= buf_data_d;
      buf_last_q      <= buf_last_d;
`ifdef FIFO_RD_TIMEOUT_EN
      idle_cnt_q      <= idle_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// -----------------------------------------------------------------------------
// tb_fifo_burst_reader
//
// Directed bench for fifo_burst_reader with default parameters (width 8,
// depth 8, BURST 4, TIMEOUT 16). A behavioural FIFO supplies data with the
// one-cycle read latency; a monitor records every accepted output word.
// -----------------------------------------------------------------------------
module tb_fifo_burst_reader;

  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [3:0] fifo_data_count = 4'd0;
  logic       fifo_rdEn;
  logic [7:0] fifo_rdData = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_last;
  logic       busy;

  int total = 0;
  int bad   = 0;

  logic [7:0] fifo_q [$];
  logic [7:0] got_data [$];
  logic       got_last [$];
  int         rd_pulses = 0;
  int         empty_rd_errs = 0;

  fifo_burst_reader #(
    .width(8), .depth(8), .BURST(4), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .fifo_empty     (fifo_empty),
    .fifo_data_count(fifo_data_count),
    .fifo_rdEn      (fifo_rdEn),
    .fifo_rdData    (fifo_rdData),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_last       (out_last),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // Behavioural FIFO: flags are registered, read data appears the cycle
  // after the strobe and holds until the next read.
  always @(posedge clk) begin
    if (fifo_rdEn && (fifo_q.size() != 0)) fifo_rdData <= fifo_q.pop_front();
    fifo_data_count <= 4'(fifo_q.size());
    fifo_empty      <= (fifo_q.size() == 0);
  end

  // Mid-cycle monitors: read strobes and accepted words.
  always @(negedge clk) begin
    if (fifo_rdEn) rd_pulses++;
    if (fifo_rdEn && fifo_empty) empty_rd_errs++;
    if (reset_n && out_valid && out_ready) begin
      got_data.push_back(out_data);
      got_last.push_back(out_last);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_got();
    got_data.delete();
    got_last.delete();
  endtask

  // Wait for n accepted words and a return to IDLE, within a cycle budget.
  task automatic wait_words(input int n, input int budget);
    int cyc = 0;
    while (((got_data.size() < n) || busy) && (cyc < budget)) begin
      tick();
      cyc++;
    end
    total++;
    if (cyc >= budget) begin
      bad++;
      $display("FAIL wait_words: got %0d words busy=%0b, required %0d words idle", got_data.size(), busy, n);
    end
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) fifo_q.push_back(8'hA0 + 8'(i));
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (fifo_rdEn !== 1'b0) begin bad++; $display("FAIL reset_rden: got %0b required 0", fifo_rdEn); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b required 0", out_valid); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b required 0", busy); end
      total++; if (out_last !== 1'b0) begin bad++; $display("FAIL reset_last: got %0b required 0", out_last); end
      total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %0h required 00", out_data); end
    end
  endtask

  task automatic test_backpressure();
    int rd0;
    clear_got();
    rd0     = rd_pulses;
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i >= 5) begin
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid: got %0b required 1", out_valid); end
        total++; if (out_data !== 8'hA0) begin bad++; $display("FAIL bp_data_stable: got %0h required a0", out_data); end
      end
    end
    total++; if (rd_pulses - rd0 !== 2) begin bad++; $display("FAIL bp_reads: got %0d required 2", rd_pulses - rd0); end
    out_ready = 1'b1;
    wait_words(8, 80);
    total++; if (got_data.size() !== 8) begin bad++; $display("FAIL bp_count: got %0d required 8", got_data.size()); end
    for (int i = 0; i < 8 && i < got_data.size(); i++) begin
      total++; if (got_data[i] !== 8'hA0 + 8'(i)) begin bad++; $display("FAIL bp_word%0d: got %0h required %0h", i, got_data[i], 8'hA0 + 8'(i)); end
      total++; if (got_last[i] !== ((i % 4) == 3)) begin bad++; $display("FAIL bp_last%0d: got %0b required %0b", i, got_last[i], (i % 4) == 3); end
    end
  endtask

  task automatic test_single_burst();
    int rd0;
    clear_got();
    rd0       = rd_pulses;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) fifo_q.push_back(8'h11 + 8'(i));
    wait_words(4, 60);
    total++; if (rd_pulses - rd0 !== 4) begin bad++; $display("FAIL burst_reads: got %0d required 4", rd_pulses - rd0); end
    total++; if (got_data.size() !== 4) begin bad++; $display("FAIL burst_count: got %0d required 4", got_data.size()); end
    for (int i = 0; i < 4 && i < got_data.size(); i++) begin
      total++; if (got_data[i] !== 8'h11 + 8'(i)) begin bad++; $display("FAIL burst_word%0d: got %0h required %0h", i, got_data[i], 8'h11 + 8'(i)); end
      total++; if (got_last[i] !== (i == 3)) begin bad++; $display("FAIL burst_last%0d: got %0b required %0b", i, got_last[i], i == 3); end
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL burst_idle: got busy=%0b required 0", busy); end
  endtask

  task automatic test_flush();
    int rd0;
    int n;
    clear_got();
    rd0 = rd_pulses;
    fifo_q.push_back(8'h41);
    fifo_q.push_back(8'h42);
`ifdef FIFO_RD_TIMEOUT_EN
    n = 0;
    while (fifo_empty && (n < 5)) begin tick(); n++; end
    n = 0;
    while (n < 40) begin
      tick();
      n++;
      if (fifo_rdEn) break;
    end
    total++; if (n !== TIMEOUT) begin bad++; $display("FAIL flush_delay: got %0d cycles required %0d", n, TIMEOUT); end
    wait_words(2, 40);
    total++; if (rd_pulses - rd0 !== 2) begin bad++; $display("FAIL flush_reads: got %0d required 2", rd_pulses - rd0); end
    total++; if (got_data.size() !== 2) begin bad++; $display("FAIL flush_count: got %0d required 2", got_data.size()); end
    for (int i = 0; i < 2 && i < got_data.size(); i++) begin
      total++; if (got_data[i] !== 8'h41 + 8'(i)) begin bad++; $display("FAIL flush_word%0d: got %0h required %0h", i, got_data[i], 8'h41 + 8'(i)); end
      total++; if (got_last[i] !== (i == 1)) begin bad++; $display("FAIL flush_last%0d: got %0b required %0b", i, got_last[i], i == 1); end
    end
`else
    repeat (40) tick();
    total++; if (rd_pulses - rd0 !== 0) begin bad++; $display("FAIL noflush_reads: got %0d required 0", rd_pulses - rd0); end
    total++; if (got_data.size() !== 0) begin bad++; $display("FAIL noflush_words: got %0d required 0", got_data.size()); end
    fifo_q.push_back(8'h43);
    fifo_q.push_back(8'h44);
    wait_words(4, 60);
    total++; if (got_data.size() !== 4) begin bad++; $display("FAIL noflush_count: got %0d required 4", got_data.size()); end
    for (int i = 0; i < 4 && i < got_data.size(); i++) begin
      total++; if (got_data[i] !== 8'h41 + 8'(i)) begin bad++; $display("FAIL noflush_word%0d: got %0h required %0h", i, got_data[i], 8'h41 + 8'(i)); end
      total++; if (got_last[i] !== (i == 3)) begin bad++; $display("FAIL noflush_last%0d: got %0b required %0b", i, got_last[i], i == 3); end
    end
`endif
  endtask

  task automatic test_reset_mid_burst();
    int rd0;
    int seen = 0;
    int cyc  = 0;
    clear_got();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) fifo_q.push_back(8'h51 + 8'(i));
    rd0 = rd_pulses;
    while ((seen < 2) && (cyc < 40)) begin
      tick();
      cyc++;
      if (fifo_rdEn) seen++;
    end
    total++; if (seen !== 2) begin bad++; $display("FAIL mid_start: got %0d reads required 2", seen); end
    reset_n = 1'b0;
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_valid: got %0b required 0", out_valid); end
    total++; if (fifo_rdEn !== 1'b0) begin bad++; $display("FAIL mid_rden: got %0b required 0", fifo_rdEn); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %0b required 0", busy); end
    total++; if (rd_pulses - rd0 !== 2) begin bad++; $display("FAIL mid_reads: got %0d required 2", rd_pulses - rd0); end
    tick();
    reset_n = 1'b1;
    fifo_q.push_back(8'h55);
    fifo_q.push_back(8'h56);
    wait_words(4, 60);
    total++; if (got_data.size() !== 4) begin bad++; $display("FAIL mid_count: got %0d required 4", got_data.size()); end
    for (int i = 0; i < 4 && i < got_data.size(); i++) begin
      total++; if (got_data[i] !== 8'h53 + 8'(i)) begin bad++; $display("FAIL mid_word%0d: got %0h required %0h", i, got_data[i], 8'h53 + 8'(i)); end
      total++; if (got_last[i] !== (i == 3)) begin bad++; $display("FAIL mid_last%0d: got %0b required %0b", i, got_last[i], i == 3); end
    end
  endtask

  task automatic test_random_ready();
    logic [7:0] exp_q [$];
    int pushed = 0;
    int cyc    = 0;
    clear_got();
    empty_rd_errs = 0;
    while (((got_data.size() < 64) || busy) && (cyc < 3000)) begin
      tick();
      cyc++;
      out_ready = 1'($urandom_range(0, 1));
      if ((pushed < 64) && (fifo_q.size() < 8)) begin
        fifo_q.push_back(8'(pushed) ^ 8'h5A);
        exp_q.push_back(8'(pushed) ^ 8'h5A);
        pushed++;
      end
    end
    total++; if (cyc >= 3000) begin bad++; $display("FAIL rand_timeout: got %0d words required 64", got_data.size()); end
    total++; if (got_data.size() !== 64) begin bad++; $display("FAIL rand_count: got %0d required 64", got_data.size()); end
    for (int i = 0; i < 64 && i < got_data.size(); i++) begin
      total++; if (got_data[i] !== exp_q[i]) begin bad++; $display("FAIL rand_word%0d: got %0h required %0h", i, got_data[i], exp_q[i]); end
      total++; if (got_last[i] !== ((i % 4) == 3)) begin bad++; $display("FAIL rand_last%0d: got %0b required %0b", i, got_last[i], (i % 4) == 3); end
    end
    total++; if (empty_rd_errs !== 0) begin bad++; $display("FAIL rand_rd_empty: got %0d required 0", empty_rd_errs); end
  endtask

  initial begin
    test_reset();
    test_backpressure();
    test_single_burst();
    test_flush();
    test_reset_mid_burst();
    test_random_ready();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
